// File: rtl/tu_chain_ctrl_pkg.sv
// rtl/tu_chain_ctrl_pkg.sv - shared types and helpers for the test-unit chain controller
// Contents: tu_state_e FSM encoding, default TIMEOUT, saturating increment.
package tu_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_HI,
    RETIRE,
    WAIT_LO,
    FINISH
  } tu_state_e;

  localparam int TIMEOUT_DEFAULT = 1024;

  // Callers pass their own all-ones limit (sized by a local localparam) and
  // truncate the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/tu_chain_ctrl_if.sv
// rtl/tu_chain_ctrl_if.sv - sequencer and chain-token signals of the chain controller
// Signals: start, up_pass (into controller); down_pass, busy, done, pass_ok,
//          timeout, latency[CNT_W], run_cnt[RUN_W] (out of controller).
// Modports: master = controller side, slave = sequencer/chain side.
interface tu_chain_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int RUN_W = 8
);
  logic             start;
  logic             up_pass;
  logic             down_pass;
  logic             busy;
  logic             done;
  logic             pass_ok;
  logic             timeout;
  logic [CNT_W-1:0] latency;
  logic [RUN_W-1:0] run_cnt;

  modport master (
    input  start, up_pass,
    output down_pass, busy, done, pass_ok, timeout, latency, run_cnt
  );

  modport slave (
    output start, up_pass,
    input  down_pass, busy, done, pass_ok, timeout, latency, run_cnt
  );
endinterface

// File: rtl/tu_chain_ctrl_wait_timer.sv
// rtl/tu_chain_ctrl_wait_timer.sv - shared wait-state cycle counter with expiry compare
// Ports: clock, rst_n (async active-low), clear (sync zero), enable (count),
//        expired (high while enabled on the TIMEOUT-th counted cycle or later).
module tu_wait_timer
  import tu_chain_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [31:0]      CNT_MAX = 32'({CNT_W{1'b1}});
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= CNT_W'(sat_inc(32'(count), CNT_MAX));
    end
  end

  // count is 0 on the first wait cycle, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/tu_chain_ctrl.sv
// rtl/tu_chain_ctrl.sv - head/tail controller that launches a pass token down a test-unit chain
// Ports: clock, rst_n (async active-low), bus (tu_chain_ctrl_if.master):
//        start in, up_pass in (token back from last unit), down_pass out (token
//        into first unit), busy, done, pass_ok, timeout, latency, run_cnt out.
module tu_chain_ctrl
  import tu_chain_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16,
  parameter int RUN_W   = 8
) (
  input  logic           clock,
  input  logic           rst_n,
  tu_chain_ctrl_if.master bus
);
  localparam logic [31:0] LAT_MAX = 32'({CNT_W{1'b1}});

  tu_state_e        state;
  logic             up_q;
  logic             down_pass;
  logic             busy;
  logic             done;
  logic             pass_ok;
  logic             timeout;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] latency;
  logic [RUN_W-1:0] run_cnt;
  logic             tmr_clear;
  logic             tmr_en;
  logic             expired;
  logic [CNT_W-1:0] lat_next;

  assign tmr_clear = (state == LAUNCH) || (state == RETIRE);
  assign tmr_en    = (state == WAIT_HI) || (state == WAIT_LO);
  assign lat_next  = CNT_W'(sat_inc(32'(lat_cnt), LAT_MAX));

  tu_wait_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (expired)
  );

  // Outputs are updated on the edge that enters a state, so down_pass/busy/done
  // are valid during the state they belong to. The detecting WAIT_HI cycle is
  // itself counted, which folds the up_q register stage into latency.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      up_q      <= 1'b0;
      down_pass <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_ok   <= 1'b0;
      timeout   <= 1'b0;
      lat_cnt   <= '0;
      latency   <= '0;
      run_cnt   <= '0;
    end else begin
      up_q <= bus.up_pass;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            timeout <= 1'b0;
            lat_cnt <= '0;
            latency <= '0;
            busy    <= 1'b1;
            if (up_q) begin
              // Token already present: the chain is dirty, fail without launching.
              state   <= FINISH;
              timeout <= 1'b1;
              pass_ok <= 1'b0;
              done    <= 1'b1;
            end else begin
              state     <= LAUNCH;
              down_pass <= 1'b1;
            end
          end
        end
        LAUNCH: state <= WAIT_HI;
        WAIT_HI: begin
          lat_cnt <= lat_next;
          // Arrival is checked before expiry so a same-cycle race succeeds.
          if (up_q) begin
            latency   <= lat_next;
            state     <= RETIRE;
            down_pass <= 1'b0;
          end else if (expired) begin
            timeout   <= 1'b1;
            pass_ok   <= 1'b0;
            state     <= RETIRE;
            down_pass <= 1'b0;
          end
        end
        RETIRE: state <= WAIT_LO;
        WAIT_LO: begin
          if (!up_q || expired) begin
            state <= FINISH;
            done  <= 1'b1;
            if (!up_q && !timeout) begin
              pass_ok <= 1'b1;
              run_cnt <= run_cnt + 1'b1;
            end else begin
              pass_ok <= 1'b0;
              timeout <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          down_pass <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.down_pass = down_pass;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass_ok   = pass_ok;
  assign bus.timeout   = timeout;
  assign bus.latency   = latency;
  assign bus.run_cnt   = run_cnt;

endmodule

// File: tb/tb_tu_chain_ctrl.sv
// tb/tb_tu_chain_ctrl.sv - directed self-checking bench for tu_chain_ctrl
module tb_tu_chain_ctrl;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  tu_chain_ctrl_if #(.CNT_W(16), .RUN_W(8)) bus_a ();
  tu_chain_ctrl_if #(.CNT_W(16), .RUN_W(8)) bus_b ();

  tu_chain_ctrl #(.TIMEOUT(64), .CNT_W(16), .RUN_W(8)) dut_a (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tu_chain_ctrl #(.TIMEOUT(16), .CNT_W(16), .RUN_W(8)) dut_b (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  // Chain models. mode: 0 wire loopback, 1 delay dly cycles both edges,
  // 2 tied 0, 3 tied 1, 4 delay rising edge only (falls with down_pass).
  int           mode_a = 2, dly_a = 1;
  int           mode_b = 2, dly_b = 1;
  logic [127:0] sr_a = '0;
  logic [127:0] sr_b = '0;

  always @(posedge clock) begin
    sr_a <= {sr_a[126:0], bus_a.down_pass};
    sr_b <= {sr_b[126:0], bus_b.down_pass};
  end

  function automatic logic chain_out(input int mode, input int dly, input logic down,
                                     input logic [127:0] sr);
    logic t;
    t = sr[dly-1];
    case (mode)
      0:       return down;
      1:       return t;
      3:       return 1'b1;
      4:       return down & t;
      default: return 1'b0;
    endcase
  endfunction

  always_comb bus_a.up_pass = chain_out(mode_a, dly_a, bus_a.down_pass, sr_a);
  always_comb bus_b.up_pass = chain_out(mode_b, dly_b, bus_b.down_pass, sr_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start on one DUT and watches negedge samples; sample 1 follows the
  // accepting edge. Optionally pokes start again at sample 3 (while busy).
  task automatic run(input bit which, input bit poke, output int done_at,
                     output int hi_cnt, output int done_cnt, output logic to1);
    logic d, dp;
    done_at  = 0;
    hi_cnt   = 0;
    done_cnt = 0;
    to1      = 1'bx;
    if (which) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      d  = which ? bus_b.done : bus_a.done;
      dp = which ? bus_b.down_pass : bus_a.down_pass;
      if (n == 1) to1 = which ? bus_b.timeout : bus_a.timeout;
      if (d) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (dp) hi_cnt++;
      if (poke && n == 3) begin
        if (which) bus_b.start = 1'b1; else bus_a.start = 1'b1;
      end else if (n == 4) begin
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
      end
      if (done_at != 0 && n >= done_at + 4) break;
      @(negedge clock);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_at, hi_cnt, done_cnt, seen;
    logic to1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    // Reset then idle
    repeat (5) @(negedge clock);
    chk("rst_down_pass", bus_a.down_pass, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_pass_ok", bus_a.pass_ok, 0);
    chk("rst_timeout", bus_a.timeout, 0);
    chk("rst_latency", bus_a.latency, 0);
    chk("rst_run_cnt", bus_a.run_cnt, 0);
    chk("rst_b_down_pass", bus_b.down_pass, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus_a.down_pass || bus_a.busy || bus_a.done || bus_b.down_pass) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Direct loopback on A
    mode_a = 0;
    run(0, 0, done_at, hi_cnt, done_cnt, to1);
    chk("loop_done_at", done_at, 5);
    chk("loop_hi_cycles", hi_cnt, 2);
    chk("loop_done_cnt", done_cnt, 1);
    chk("loop_pass_ok", bus_a.pass_ok, 1);
    chk("loop_latency", bus_a.latency, 1);
    chk("loop_run_cnt", bus_a.run_cnt, 1);
    chk("loop_timeout", bus_a.timeout, 0);
    chk("loop_busy_after", bus_a.busy, 0);

    // 37-cycle chain on A, three runs, second one poked while busy
    mode_a = 1;
    dly_a  = 37;
    repeat (40) @(negedge clock);
    for (int r = 0; r < 3; r++) begin
      run(0, r == 1, done_at, hi_cnt, done_cnt, to1);
      chk("d37_latency", bus_a.latency, 38);
      chk("d37_done_at", done_at, 79);
      chk("d37_done_cnt", done_cnt, 1);
      chk("d37_pass_ok", bus_a.pass_ok, 1);
    end
    chk("d37_run_cnt", bus_a.run_cnt, 4);

    // Never-returning chain on B (TIMEOUT=16)
    mode_b = 2;
    run(1, 0, done_at, hi_cnt, done_cnt, to1);
    chk("dead_done_at", done_at, 20);
    chk("dead_hi_cycles", hi_cnt, 17);
    chk("dead_done_cnt", done_cnt, 1);
    chk("dead_pass_ok", bus_b.pass_ok, 0);
    chk("dead_timeout", bus_b.timeout, 1);
    chk("dead_run_cnt", bus_b.run_cnt, 0);

    // Good run on B clears timeout at its start
    mode_b = 0;
    run(1, 0, done_at, hi_cnt, done_cnt, to1);
    chk("good_timeout_cleared", to1, 0);
    chk("good_pass_ok", bus_b.pass_ok, 1);
    chk("good_timeout", bus_b.timeout, 0);
    chk("good_run_cnt", bus_b.run_cnt, 1);

    // Token arriving exactly on the expiry cycle succeeds
    mode_b = 4;
    dly_b  = 15;
    repeat (40) @(negedge clock);
    run(1, 0, done_at, hi_cnt, done_cnt, to1);
    chk("race_pass_ok", bus_b.pass_ok, 1);
    chk("race_timeout", bus_b.timeout, 0);
    chk("race_latency", bus_b.latency, 16);
    chk("race_run_cnt", bus_b.run_cnt, 2);

    // One cycle later is a timeout
    dly_b = 16;
    repeat (40) @(negedge clock);
    run(1, 0, done_at, hi_cnt, done_cnt, to1);
    chk("late_pass_ok", bus_b.pass_ok, 0);
    chk("late_timeout", bus_b.timeout, 1);
    chk("late_run_cnt", bus_b.run_cnt, 2);

    // Stuck-high chain on A
    mode_a = 3;
    repeat (2) @(negedge clock);
    run(0, 0, done_at, hi_cnt, done_cnt, to1);
    chk("stuck_done_at", done_at, 1);
    chk("stuck_hi_cycles", hi_cnt, 0);
    chk("stuck_pass_ok", bus_a.pass_ok, 0);
    chk("stuck_timeout", bus_a.timeout, 1);
    chk("stuck_run_cnt", bus_a.run_cnt, 4);

    // Reset asserted mid-run during WAIT_HI
    mode_a = 1;
    dly_a  = 37;
    repeat (40) @(negedge clock);
    bus_a.start = 1'b1;
    @(negedge clock);
    bus_a.start = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_busy_before", bus_a.busy, 1);
    chk("mid_down_pass_before", bus_a.down_pass, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_down_pass_async", bus_a.down_pass, 0);
    chk("mid_busy_async", bus_a.busy, 0);
    @(negedge clock);
    rst_n = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus_a.done || bus_a.busy) seen++;
    end
    chk("mid_no_done", seen, 0);
    chk("mid_run_cnt", bus_a.run_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
